// File: rtl/out_bank_scheduler.sv
`default_nettype none
// out_bank_scheduler: read-side scheduler for a ping-pong pair of output banks.
// Tracks load order, starts each bank's read burst and muxes it onto one framed stream.
module out_bank_scheduler #(
  parameter int HDDW            = 32,
  parameter int MAXOUTCYCLES    = 223,
  parameter int CYCLECOUNTWIDTH = 8,
  parameter int IFG             = 2,
  parameter int START_TIMEOUT   = 4
) (
  input  logic            rdclk,
  input  logic            rst,
  input  logic [1:0]      bank_full,
  input  logic            host_ready,
  input  logic [1:0]      dv_b,
  input  logic [HDDW-1:0] hd_b0,
  input  logic [HDDW-1:0] hd_b1,
  output logic [1:0]      rd_en_b,
  output logic [HDDW-1:0] hd_out,
  output logic            out_valid,
  output logic            sof,
  output logic            eof,
  output logic [1:0]      bank_free,
  output logic            busy,
  output logic            err_overflow,
  output logic            err_timeout
);

  localparam int TW = $clog2(START_TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [CYCLECOUNTWIDTH-1:0] LAST_BEAT = CYCLECOUNTWIDTH'(MAXOUTCYCLES - 1);
  localparam logic [CYCLECOUNTWIDTH-1:0] BEAT_ONE  = CYCLECOUNTWIDTH'(1);
  localparam logic [3:0] GAP_LAST = (IFG > 0) ? 4'(IFG - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAITDV = 3'd2,
    S_STREAM = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam state_t S_AFTER_FRAME = (IFG == 0) ? S_IDLE : S_GAP;

  state_t                     state_q;
  logic                       cur_q;
  logic                       q0_q, q1_q;
  logic [1:0]                 cnt_q;
  logic [CYCLECOUNTWIDTH-1:0] beat_q;
  logic [TW-1:0]              tmo_q;
  logic [3:0]                 gap_q;
  logic [1:0]                 rd_en_b_q;
  logic [HDDW-1:0]            hd_out_q;
  logic                       out_valid_q, sof_q, eof_q;
  logic [1:0]                 bank_free_q, bank_free_d;
  logic                       err_overflow_q, err_timeout_q;

  logic [1:0]      accept, reject, release_mask;
  logic            qp0, qp1;
  logic [1:0]      qpcnt;
  logic            pop, dv_cur, take_beat, last_beat, tmo_hit;
  logic [HDDW-1:0] hd_cur;

  // The queue is viewed after this cycle's pushes so a load seen in IDLE issues rd_en next cycle.
  always_comb begin
    accept = bank_full & bank_free_q;
    reject = bank_full & ~bank_free_q;
    qp0    = q0_q;
    qp1    = q1_q;
    qpcnt  = cnt_q;
    if (accept[0]) begin
      if (qpcnt == 2'd0) qp0 = 1'b0;
      else               qp1 = 1'b0;
      qpcnt = qpcnt + 2'd1;
    end
    if (accept[1]) begin
      if (qpcnt == 2'd0) qp0 = 1'b1;
      else               qp1 = 1'b1;
      qpcnt = qpcnt + 2'd1;
    end
    dv_cur    = dv_b[cur_q];
    hd_cur    = cur_q ? hd_b1 : hd_b0;
    pop       = (state_q == S_IDLE) && host_ready && (qpcnt != 2'd0);
    take_beat = ((state_q == S_WAITDV) || (state_q == S_STREAM)) && dv_cur;
    last_beat = (beat_q == LAST_BEAT);
    tmo_hit   = (state_q == S_WAITDV) && !dv_cur && (tmo_q == TMO_LIMIT);
    release_mask = 2'b00;
    if ((out_valid_q && eof_q) || tmo_hit) release_mask[cur_q] = 1'b1;
    bank_free_d = (bank_free_q & ~accept) | release_mask;
  end

  always_ff @(posedge rdclk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cur_q          <= 1'b0;
      q0_q           <= 1'b0;
      q1_q           <= 1'b0;
      cnt_q          <= 2'd0;
      beat_q         <= '0;
      tmo_q          <= '0;
      gap_q          <= 4'd0;
      rd_en_b_q      <= 2'b00;
      hd_out_q       <= '0;
      out_valid_q    <= 1'b0;
      sof_q          <= 1'b0;
      eof_q          <= 1'b0;
      bank_free_q    <= 2'b11;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      rd_en_b_q   <= 2'b00;
      out_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      bank_free_q <= bank_free_d;
      if (|reject) err_overflow_q <= 1'b1;

      q0_q  <= pop ? qp1 : qp0;
      q1_q  <= qp1;
      cnt_q <= qpcnt - {1'b0, pop};

      if (take_beat) begin
        hd_out_q    <= hd_cur;
        out_valid_q <= 1'b1;
        sof_q       <= (beat_q == '0);
        eof_q       <= last_beat;
        beat_q      <= last_beat ? '0 : beat_q + BEAT_ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_q     <= qp0;
            rd_en_b_q <= qp0 ? 2'b10 : 2'b01;
            tmo_q     <= TMO_ONE;
            state_q   <= S_START;
          end
        end
        S_START: begin
          tmo_q   <= tmo_q + TMO_ONE;
          state_q <= S_WAITDV;
        end
        S_WAITDV: begin
          if (tmo_hit) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else if (!dv_cur) begin
            tmo_q <= tmo_q + TMO_ONE;
          end else if (last_beat) begin
            gap_q   <= 4'd0;
            state_q <= S_AFTER_FRAME;
          end else begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (dv_cur && last_beat) begin
            gap_q   <= 4'd0;
            state_q <= S_AFTER_FRAME;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else                   gap_q   <= gap_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en_b      = rd_en_b_q;
  assign hd_out       = hd_out_q;
  assign out_valid    = out_valid_q;
  assign sof          = sof_q;
  assign eof          = eof_q;
  assign bank_free    = bank_free_q;
  assign busy         = (state_q != S_IDLE) || (cnt_q != 2'd0);
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_out_bank_scheduler.sv
`default_nettype none
// tb_out_bank_scheduler: randomized bench with a frame-level reference model of the scheduler.
module tb_out_bank_scheduler;

  localparam int HDDW = 32;
  localparam int MAXOUTCYCLES = 223;
  localparam int CYCLECOUNTWIDTH = 8;
  localparam int IFG = 2;
  localparam int START_TIMEOUT = 4;

  logic            rdclk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      bank_full = 2'b00;
  logic            host_ready = 1'b0;
  logic [1:0]      dv_b = 2'b00;
  logic [HDDW-1:0] hd_b0 = '0;
  logic [HDDW-1:0] hd_b1 = '0;
  logic [1:0]      rd_en_b;
  logic [HDDW-1:0] hd_out;
  logic            out_valid, sof, eof;
  logic [1:0]      bank_free;
  logic            busy, err_overflow, err_timeout;

  always #5 rdclk = ~rdclk;

  out_bank_scheduler #(
    .HDDW(HDDW), .MAXOUTCYCLES(MAXOUTCYCLES), .CYCLECOUNTWIDTH(CYCLECOUNTWIDTH),
    .IFG(IFG), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .rdclk(rdclk), .rst(rst), .bank_full(bank_full), .host_ready(host_ready),
    .dv_b(dv_b), .hd_b0(hd_b0), .hd_b1(hd_b1), .rd_en_b(rd_en_b), .hd_out(hd_out),
    .out_valid(out_valid), .sof(sof), .eof(eof), .bank_free(bank_free), .busy(busy),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frames leave in load order; each frame is a read request, a short
  // wait for the bank, MAXOUTCYCLES delivered words, then IFG quiet cycles.
  int              m_pend[$];
  int              m_cur = 0;
  int              m_phase = 0;  // 0 idle, 1 request issued, 2 awaiting bank, 3 streaming, 4 gap
  int              m_beat = 0;
  int              m_age = 0;
  int              m_gapn = 0;
  int              m_eof_bank = 0;
  logic [1:0]      m_rd = 2'b00;
  logic [1:0]      m_free = 2'b11;
  logic [HDDW-1:0] m_hd = '0;
  logic            m_val = 1'b0, m_sof = 1'b0, m_eof = 1'b0;
  logic            m_ovf = 1'b0, m_tmo = 1'b0, m_busy = 1'b0;

  task automatic model_emit();
    m_hd  = m_cur ? hd_b1 : hd_b0;
    m_val = 1'b1;
    m_sof = (m_beat == 0);
    m_eof = (m_beat == MAXOUTCYCLES - 1);
    if (m_eof) begin
      m_beat     = 0;
      m_eof_bank = m_cur;
      m_gapn     = 0;
      m_phase    = (IFG == 0) ? 0 : 4;
    end else begin
      m_beat++;
      m_phase = 3;
    end
  endtask

  task automatic model_step();
    logic [1:0] old_free;
    logic       freed_by_eof;
    if (!rst) begin
      m_pend.delete();
      m_cur = 0; m_phase = 0; m_beat = 0; m_age = 0; m_gapn = 0;
      m_rd = 2'b00; m_free = 2'b11; m_hd = '0;
      m_val = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
      m_ovf = 1'b0; m_tmo = 1'b0; m_busy = 1'b0;
      return;
    end
    freed_by_eof = m_val && m_eof;
    old_free = m_free;
    m_rd = 2'b00; m_val = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bank_full[i]) begin
        if (old_free[i]) begin
          m_pend.push_back(i);
          m_free[i] = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (freed_by_eof) m_free[m_eof_bank] = 1'b1;
    case (m_phase)
      0: if (host_ready && m_pend.size() > 0) begin
           m_cur = m_pend.pop_front();
           m_rd[m_cur] = 1'b1;
           m_age = 1;
           m_phase = 1;
         end
      1: begin m_age++; m_phase = 2; end
      2: if (dv_b[m_cur]) model_emit();
         else if (m_age == START_TIMEOUT) begin
           m_tmo = 1'b1;
           m_free[m_cur] = 1'b1;
           m_phase = 0;
         end else m_age++;
      3: if (dv_b[m_cur]) model_emit();
      4: begin m_gapn++; if (m_gapn == IFG) m_phase = 0; end
      default: m_phase = 0;
    endcase
    m_busy = (m_phase != 0) || (m_pend.size() != 0);
  endtask

  // Bank emulation: after rd_en a bank waits 0..2 extra cycles, then delivers a frame with
  // random stalls; a muted bank never answers. Idle banks toggle dv randomly as noise.
  int act[2] = '{0, 0};
  int left[2] = '{0, 0};
  int dly[2] = '{0, 0};
  bit mute[2] = '{0, 0};
  int stall_pct = 0;
  bit force_mute = 0;
  bit rand_mute = 0;

  task automatic drive_banks();
    for (int i = 0; i < 2; i++) begin
      logic            d;
      logic [HDDW-1:0] w;
      w = $urandom;
      d = 1'b0;
      if (rd_en_b[i] === 1'b1) begin
        act[i]  = 1;
        mute[i] = force_mute || (rand_mute && $urandom_range(0, 7) == 0);
        left[i] = mute[i] ? 8 : MAXOUTCYCLES;
        dly[i]  = $urandom_range(0, 2);
      end else if (act[i] != 0) begin
        if (mute[i]) begin
          left[i]--;
          if (left[i] == 0) act[i] = 0;
        end else if (dly[i] > 0) begin
          dly[i]--;
        end else begin
          d = (left[i] == MAXOUTCYCLES) || ($urandom_range(0, 99) >= stall_pct);
          if (d) begin
            left[i]--;
            if (left[i] == 0) act[i] = 0;
          end
        end
      end else begin
        d = ($urandom_range(0, 4) == 0);
      end
      dv_b[i] = d;
      if (i == 0) hd_b0 = w;
      else        hd_b1 = w;
    end
  endtask

  int cycle_no = 0;
  int last_eof = -1;
  bit gap_chk = 0;

  task automatic cyc(input logic [1:0] bf, input logic hr);
    @(negedge rdclk);
    bank_full  = bf;
    host_ready = hr;
    drive_banks();
    @(posedge rdclk);
    model_step();
    cycle_no++;
    #1;
    check_eq("rd_en_b", rd_en_b, m_rd);
    check_eq("out_valid", out_valid, m_val);
    check_eq("sof", sof, m_sof);
    check_eq("eof", eof, m_eof);
    check_eq("bank_free", bank_free, m_free);
    check_eq("busy", busy, m_busy);
    check_eq("err_overflow", err_overflow, m_ovf);
    check_eq("err_timeout", err_timeout, m_tmo);
    if (m_val) check_eq("hd_out", hd_out, m_hd);
    if (gap_chk) begin
      if (eof === 1'b1 && out_valid === 1'b1) last_eof = cycle_no;
      if (rd_en_b !== 2'b00 && last_eof >= 0) begin
        check_eq("eof_to_rd_en", cycle_no - last_eof, IFG + 1);
        last_eof = -1;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input logic hr);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cyc(2'b00, hr);
      n++;
    end
    check_eq("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    cyc(2'b00, 1'b0);
    cyc(2'b00, 1'b0);
    check_eq("reset_hd_out", hd_out, '0);
    rst = 1'b1;

    // Single frame from bank 0 with continuous data
    cyc(2'b01, 1'b1);
    wait_idle(600, 1'b1);

    // Simultaneous loads: bank 0 then bank 1, with the inter-frame gap measured
    gap_chk = 1;
    cyc(2'b11, 1'b1);
    wait_idle(1200, 1'b1);
    gap_chk = 0;
    last_eof = -1;

    // Host not ready holds the loaded bank
    stall_pct = 15;
    cyc(2'b10, 1'b0);
    repeat (4) cyc(2'b00, 1'b0);
    check_eq("held_busy", busy, 1'b1);
    cyc(2'b00, 1'b1);
    check_eq("ready_rd_en", rd_en_b, 2'b10);
    wait_idle(600, 1'b1);

    // Reload of the bank being streamed
    cyc(2'b01, 1'b1);
    repeat (20) cyc(2'b00, 1'b1);
    cyc(2'b01, 1'b1);
    check_eq("overflow_set", err_overflow, 1'b1);
    wait_idle(600, 1'b1);
    check_eq("overflow_sticky", err_overflow, 1'b1);

    // Bank never answers
    force_mute = 1;
    cyc(2'b10, 1'b1);
    repeat (6) cyc(2'b00, 1'b1);
    force_mute = 0;
    check_eq("timeout_set", err_timeout, 1'b1);
    check_eq("timeout_free", bank_free, 2'b11);
    wait_idle(100, 1'b1);

    // Reset in the middle of a frame, then a clean restart
    cyc(2'b01, 1'b1);
    n = 0;
    while (m_beat != 100 && n < 600) begin
      cyc(2'b00, 1'b1);
      n++;
    end
    check_eq("beat100_reached", m_beat, 100);
    rst = 1'b0;
    cyc(2'b00, 1'b1);
    rst = 1'b1;
    check_eq("midframe_rst_hd", hd_out, '0);
    check_eq("midframe_rst_err", {err_overflow, err_timeout}, 2'b00);
    cyc(2'b01, 1'b1);
    wait_idle(600, 1'b1);

    // Random traffic
    stall_pct = 25;
    rand_mute = 1;
    repeat (3000) begin
      cyc({($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)},
          ($urandom_range(0, 3) != 0));
    end
    rand_mute = 0;
    wait_idle(1500, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
